faha: RTL and testbench
=======================

// Module: faha
// PURPOSE
//  Registered ripple-carry adder built strictly from half-adder pairs.
//  Per bit: HA1 adds a[i]^b[i]; HA2 adds the carry-in; carry-out = HA1.c | HA2.c.
//  Computes {cout,sum} = a + b + c and registers the result once per clock.
//  Arithmetic leaf for datapaths; WIDTH=1 is a classic registered full adder.
// PARAMETERS
//  WIDTH  1  operand width in bits (legal range 1..64)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      reset, asynchronous assert, active-low
//  in_valid  in   1      a/b/c are sampled on this clk edge when high
//  a         in   WIDTH  operand A, unsigned
//  b         in   WIDTH  operand B, unsigned
//  c         in   1      carry-in
//  sum       out  WIDTH  registered sum bits
//  cout      out  1      registered carry-out of the MSB
//  out_valid out  1      high for one cycle with each new result
//  One clock (clk); reset is asynchronous and active-low (rst_n).
// BEHAVIOUR
//  - Reset: when rst_n=0, immediately (no clock needed) sum=0, cout=0, out_valid=0.
//    Deassertion takes effect at the next clk edge.
//  - Half adder: s = x^y, co = x&y. Stage i: t=a[i]^b[i], g=a[i]&b[i];
//    sum[i] = t^carry[i], p = t&carry[i], carry[i+1] = g|p; carry[0]=c.
//  - Result is combinational ripple from inputs; only the output registers clock it.
//  - Latency 1: values sampled at edge N with in_valid=1 appear on sum/cout at edge N
//    with out_valid=1 after edge N (i.e. valid during cycle N+1).
//  - in_valid=0 at an edge: sum/cout hold their previous value; out_valid drops to 0.
//  - Back-to-back in_valid: one result per cycle, no bubbles, no back-pressure.
//  - Width rules: no truncation; the full WIDTH+1-bit result is {cout,sum}.
//    Wrap: a=b=all-ones, c=1 -> sum=all-ones, cout=1.
//  - Reset mid-operation: a pending result is discarded; out_valid=0 until the next
//    in_valid edge after release.
//  - X on inputs while in_valid=0 must not disturb the outputs.
// CONFIGURATION
//  FAHA_OVF_EN defined: adds output port ovf (1 bit, registered, same timing as sum).
//    ovf = carry[WIDTH] ^ carry[WIDTH-1], the two's-complement signed overflow.
//    ovf resets to 0 and holds when in_valid=0.
//  FAHA_OVF_EN undefined: no ovf port and no overflow logic; all else is identical.
// TESTING
//  1. WIDTH=1: rst_n=0, then release; sweep c every cycle, b every 2 cycles, a every
//     4 cycles over all 8 combinations -> {cout,sum} = 00,01,01,10,01,10,10,11.
//  2. Async reset: drive rst_n low between edges while out_valid=1 -> sum/cout/
//     out_valid go 0 before the next edge.
//  3. WIDTH=8: a=8'hFF, b=8'h00, c=1 -> sum=8'h00, cout=1, out_valid=1 one cycle later.
//  4. Hold: a=3, b=4, c=0, in_valid=1, then in_valid=0 with new a/b values ->
//     sum stays 7, out_valid=1 then 0.
//  5. Streaming, WIDTH=4: in_valid=1 for 3 cycles with (1,2,0),(7,9,1),(15,15,1) ->
//     results (3,0),(1,1),(15,1) on consecutive cycles.
//  6. With FAHA_OVF_EN, WIDTH=8: a=8'h7F, b=8'h01, c=0 -> sum=8'h80, ovf=1;
//     a=8'hFF, b=8'h01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/faha.sv
// Registered ripple-carry adder built from half-adder pairs: {cout,sum}=a+b+c.
// Ports: clk, rst_n, in_valid, a, b, c -> sum, cout, out_valid (+ovf with FAHA_OVF_EN).
module faha #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FAHA_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             vld_q;

  assign carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic t, g, p;
    // HA1: operand bits
    assign t = a[i] ^ b[i];
    assign g = a[i] & b[i];
    // HA2: fold in the ripple carry
    assign sum_d[i] = t ^ carry[i];
    assign p = t & carry[i];
    assign carry[i+1] = g | p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[WIDTH];
      end
    end
  end

`ifdef FAHA_OVF_EN
  logic ovf_q;

  // signed overflow: carry into MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_faha.sv
// Directed self-checking bench for faha at WIDTH=1, 4 and 8.
// Each step drives on a falling edge and checks on the next falling edge.
module tb_faha;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       co4, ov4;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       co8, ov8;
`ifdef FAHA_OVF_EN
  logic       of1, of4, of8;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  faha #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .a(a1), .b(b1), .c(c1),
    .sum(s1), .cout(co1),
`ifdef FAHA_OVF_EN
    .ovf(of1),
`endif
    .out_valid(ov1)
  );

  faha #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .a(a4), .b(b4), .c(c4),
    .sum(s4), .cout(co4),
`ifdef FAHA_OVF_EN
    .ovf(of4),
`endif
    .out_valid(ov4)
  );

  faha #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .a(a8), .b(b8), .c(c8),
    .sum(s8), .cout(co8),
`ifdef FAHA_OVF_EN
    .ovf(of8),
`endif
    .out_valid(ov8)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] t1 [8];

  initial begin
    t1[0] = 2'b00; t1[1] = 2'b01; t1[2] = 2'b01; t1[3] = 2'b10;
    t1[4] = 2'b01; t1[5] = 2'b10; t1[6] = 2'b10; t1[7] = 2'b11;

    // reset state
    @(negedge clk);
    chk("rst_w1", {13'd0, ov1, co1, s1}, 16'h0);
    chk("rst_w4", {10'd0, ov4, co4, s4}, 16'h0);
    chk("rst_w8", {6'd0, ov8, co8, s8}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // full-adder truth table sweep
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0]; v1 = 1'b1;
      @(negedge clk);
      chk($sformatf("fa_%0d", i), {14'd0, co1, s1}, {14'd0, t1[i]});
      chk($sformatf("fa_vld_%0d", i), {15'd0, ov1}, 16'h1);
    end
    v1 = 1'b0; a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
    @(negedge clk);
    chk("fa_hold", {13'd0, ov1, co1, s1}, 16'h3);

    // asynchronous reset between edges
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(negedge clk);
    chk("ar_pre", {13'd0, ov1, co1, s1}, 16'h5);
    #2 rst_n = 1'b0;
    #1 chk("ar_now", {13'd0, ov1, co1, s1}, 16'h0);
    @(negedge clk);
    chk("ar_held", {13'd0, ov1, co1, s1}, 16'h0);
    rst_n = 1'b1; v1 = 1'b0;
    @(negedge clk);
    chk("ar_rel", {13'd0, ov1, co1, s1}, 16'h0);

    // WIDTH=8 carry through all bits
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    @(negedge clk);
    chk("w8_ff1", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b1, 8'h00});
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(negedge clk);
    chk("w8_wrap", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b1, 8'hFF});

    // hold when in_valid drops, X on inputs ignored
    a8 = 8'd3; b8 = 8'd4; c8 = 1'b0;
    @(negedge clk);
    chk("hold_a", {6'd0, ov8, co8, s8}, {6'd0, 1'b1, 1'b0, 8'd7});
    v8 = 1'b0; a8 = 'x; b8 = 8'h55; c8 = 1'bx;
    @(negedge clk);
    chk("hold_b", {6'd0, ov8, co8, s8}, {6'd0, 1'b0, 1'b0, 8'd7});
    @(negedge clk);
    chk("hold_c", {6'd0, ov8, co8, s8}, {6'd0, 1'b0, 1'b0, 8'd7});

    // back-to-back stream, WIDTH=4
    a4 = 4'd1; b4 = 4'd2; c4 = 1'b0; v4 = 1'b1;
    @(negedge clk);
    chk("st_0", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b0, 4'd3});
    a4 = 4'd7; b4 = 4'd9; c4 = 1'b1;
    @(negedge clk);
    chk("st_1", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b1, 4'd1});
    a4 = 4'd15; b4 = 4'd15; c4 = 1'b1;
    @(negedge clk);
    chk("st_2", {10'd0, ov4, co4, s4}, {10'd0, 1'b1, 1'b1, 4'd15});
    v4 = 1'b0;
    @(negedge clk);
    chk("st_end", {10'd0, ov4, co4, s4}, {10'd0, 1'b0, 1'b1, 4'd15});

`ifdef FAHA_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    chk("ovf_pos", {5'd0, of8, ov8, co8, s8}, {5'd0, 1'b1, 1'b1, 1'b0, 8'h80});
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(negedge clk);
    chk("ovf_neg", {5'd0, of8, ov8, co8, s8}, {5'd0, 1'b0, 1'b1, 1'b1, 8'h00});
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    @(negedge clk);
    chk("ovf_min", {5'd0, of8, ov8, co8, s8}, {5'd0, 1'b1, 1'b1, 1'b1, 8'h00});
    v8 = 1'b0; a8 = 'x;
    @(negedge clk);
    chk("ovf_hold", {5'd0, of8, ov8, co8, s8}, {5'd0, 1'b1, 1'b0, 1'b1, 8'h00});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
